button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 126 ++++++++++++
 tb/tb_button_conditioner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Synchronizes and debounces a raw pushbutton, producing a clean
//             level, single-cycle press/release strobes and a press counter.
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COUNT_WIDTH     = 4
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic                   btn,
  output logic                   debounced,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic [COUNT_WIDTH-1:0] press_count
);

  // Timer only has to reach DEBOUNCE_CYCLES-1, so ceil(log2) bits suffice.
  localparam int TIMER_WIDTH = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] C_TIMER_MAX = TIMER_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  logic                   r_sync1;
  logic                   r_sync2;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [TIMER_WIDTH-1:0] w_timer_next;
  logic                   w_accept_high;
  logic                   w_accept_low;

  // Two-flop synchronizer; only r_sync2 feeds the debounce logic.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic: a level change must be seen for DEBOUNCE_CYCLES
  // consecutive samples in the WAIT state before it is accepted.
  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_accept_high = 1'b0;
    w_accept_low  = 1'b0;
    case (r_state)
      STABLE_LOW: begin
        w_timer_next = '0;
        if (r_sync2) begin
          w_state_next = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (!r_sync2) begin
          w_state_next = STABLE_LOW;
          w_timer_next = '0;
        end else if (r_timer == C_TIMER_MAX) begin
          w_state_next  = STABLE_HIGH;
          w_timer_next  = '0;
          w_accept_high = 1'b1;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      STABLE_HIGH: begin
        w_timer_next = '0;
        if (!r_sync2) begin
          w_state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (r_sync2) begin
          w_state_next = STABLE_HIGH;
          w_timer_next = '0;
        end else if (r_timer == C_TIMER_MAX) begin
          w_state_next = STABLE_LOW;
          w_timer_next = '0;
          w_accept_low = 1'b1;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_next = STABLE_LOW;
        w_timer_next = '0;
      end
    endcase
  end

  // State, timer and registered outputs; outputs track the state being entered
  // so that debounced and the strobes change on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state       <= STABLE_LOW;
      r_timer       <= '0;
      debounced     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      debounced     <= (w_state_next == STABLE_HIGH) || (w_state_next == WAIT_LOW);
      press_pulse   <= w_accept_high;
      release_pulse <= w_accept_low;
      if (w_accept_high) begin
        press_count <= press_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4,
//             COUNT_WIDTH=4) with a run-length reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int CW  = 4;

  logic          CLK;
  logic          CLR;
  logic          btn;
  logic          debounced;
  logic          press_pulse;
  logic          release_pulse;
  logic [CW-1:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two-sample delay line, then an accepted level that flips
  // once DEB+1 consecutive delayed samples disagree with it.
  logic          m_s1, m_s2, m_lvl, m_press, m_rel;
  int            m_run;
  logic [CW-1:0] m_cnt;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .COUNT_WIDTH    (CW)
  ) dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .btn          (btn),
    .debounced    (debounced),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic clr, input logic b);
    logic s;
    if (clr) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
      m_press = 0; m_rel = 0; m_cnt = '0;
    end else begin
      s       = m_s2;
      m_press = 0;
      m_rel   = 0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = s;
          m_run = 0;
          if (s) begin
            m_press = 1;
            m_cnt   = m_cnt + 1'b1;
          end else begin
            m_rel = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  // One clock: advance model with the driven inputs, then compare 1 ns later.
  task automatic tick();
    @(posedge CLK);
    model_edge(CLR, btn);
    #1;
    check("debounced", 32'(debounced), 32'(m_lvl));
    check("press_pulse", 32'(press_pulse), 32'(m_press));
    check("release_pulse", 32'(release_pulse), 32'(m_rel));
    check("press_count", 32'(press_count), 32'(m_cnt));
    check("pulse_exclusive", 32'(press_pulse & release_pulse), 32'd0);
  endtask

  // Counts edges from the first one sampling the new input up to the strobe.
  task automatic wait_pulse(input bit want_press, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (want_press ? press_pulse : release_pulse) break;
    end
  endtask

  initial begin
    int n;
    int run;
    CLR = 1'b1;
    btn = 1'b0;
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_press = 0; m_rel = 0; m_cnt = '0;

    // Reset state
    tick();
    tick();
    check("reset_debounced", 32'(debounced), 32'd0);
    check("reset_count", 32'(press_count), 32'd0);
    CLR = 1'b0;
    tick();

    // Short glitches 1,0,1,0 every 2 cycles must be rejected
    for (int g = 0; g < 4; g++) begin
      btn = (g % 2 == 0);
      tick();
      tick();
    end
    btn = 1'b0;
    repeat (10) tick();
    check("glitch_debounced", 32'(debounced), 32'd0);
    check("glitch_count", 32'(press_count), 32'd0);

    // Clean press: strobe on the 7th edge counting the first sampling edge
    btn = 1'b1;
    wait_pulse(1'b1, n);
    check("press_latency", 32'(n), 32'(DEB + 3));
    check("press_debounced", 32'(debounced), 32'd1);
    check("press_count_1", 32'(press_count), 32'd1);
    tick();
    check("press_one_cycle", 32'(press_pulse), 32'd0);
    repeat (3) tick();

    // Clean release
    btn = 1'b0;
    wait_pulse(1'b0, n);
    check("release_latency", 32'(n), 32'(DEB + 3));
    check("release_debounced", 32'(debounced), 32'd0);
    tick();
    check("release_one_cycle", 32'(release_pulse), 32'd0);

    // 16 press/release pairs from reset: count 1..15 then wraps to 0
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int p = 0; p < 16; p++) begin
      btn = 1'b1;
      repeat (10) tick();
      check("wrap_count", 32'(press_count), 32'((p + 1) % 16));
      btn = 1'b0;
      repeat (10) tick();
    end

    // Reset while qualifying a press with the button still held
    btn = 1'b1;
    repeat (4) tick();
    CLR = 1'b1;
    tick();
    check("clr_debounced", 32'(debounced), 32'd0);
    check("clr_press", 32'(press_pulse), 32'd0);
    check("clr_count", 32'(press_count), 32'd0);
    CLR = 1'b0;
    wait_pulse(1'b1, n);
    check("requalify_latency", 32'(n), 32'(DEB + 3));
    check("requalify_count", 32'(press_count), 32'd1);

    // Reset landing exactly on the would-be acceptance edge
    btn = 1'b0;
    repeat (10) tick();
    btn = 1'b1;
    repeat (DEB + 2) tick();
    CLR = 1'b1;
    tick();
    check("clr_priority_press", 32'(press_pulse), 32'd0);
    check("clr_priority_deb", 32'(debounced), 32'd0);
    CLR = 1'b0;

    // Randomized bouncing with occasional resets
    for (int r = 0; r < 120; r++) begin
      btn = 1'($urandom_range(0, 1));
      run = $urandom_range(1, 12);
      CLR = ($urandom_range(0, 39) == 0);
      tick();
      CLR = 1'b0;
      repeat (run - 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
